// File: rtl/mouse_position_tracker.sv
// Tracks an absolute pointer position from PS/2 mouse packets, clamped to the screen area.
// Optional build macro MOUSE_POS_INVERT_Y_EN negates the Y delta so PS/2 "up" moves the pointer up.
module mouse_position_tracker #(
   parameter int unsigned LIMIT_X = 160,
   parameter int unsigned LIMIT_Y = 120
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       SEND_INTERRUPT,
   input  logic [7:0] MOUSE_STATUS,
   input  logic [7:0] MOUSE_DX,
   input  logic [7:0] MOUSE_DY,
   output logic [7:0] MOUSE_X,
   output logic [7:0] MOUSE_Y,
   output logic [2:0] MOUSE_BUTTONS,
   output logic       POS_VALID,
   output logic       BUSY,
   output logic [7:0] DROP_CNT
);

   typedef enum logic [1:0] {StIdle, StSum, StClamp, StDone} state_e;

   localparam logic signed [9:0] MaxX  = 10'(LIMIT_X - 1);
   localparam logic signed [9:0] MaxY  = 10'(LIMIT_Y - 1);
   localparam logic [7:0]        HomeX = 8'(LIMIT_X / 2);
   localparam logic [7:0]        HomeY = 8'(LIMIT_Y / 2);

   state_e            state_q, state_d;
   logic [7:0]        status_q, dx_q, dy_q;
   logic signed [9:0] sum_x_q, sum_y_q;
   logic signed [9:0] dx_ext, dy_raw, dy_ext;
   logic              unused_status;

   assign unused_status = status_q[3];

   function automatic logic [7:0] clamp(input logic signed [9:0] v, input logic signed [9:0] hi);
      if (v[9]) begin
         return 8'd0;
      end else if (v > hi) begin
         return hi[7:0];
      end else begin
         return v[7:0];
      end
   endfunction

   // Overflowed axes contribute no motion; 10 bits hold 255+256 and -256 without wrap.
   always_comb begin
      dx_ext = status_q[6] ? 10'sd0 : {{2{status_q[4]}}, dx_q};
      dy_raw = status_q[7] ? 10'sd0 : {{2{status_q[5]}}, dy_q};
`ifdef MOUSE_POS_INVERT_Y_EN
      dy_ext = -dy_raw;
`else
      dy_ext = dy_raw;
`endif
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (SEND_INTERRUPT) state_d = StSum;
         StSum:   state_d = StClamp;
         StClamp: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign POS_VALID = (state_q == StDone);
   assign BUSY      = (state_q != StIdle);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         status_q      <= '0;
         dx_q          <= '0;
         dy_q          <= '0;
         sum_x_q       <= '0;
         sum_y_q       <= '0;
         MOUSE_X       <= HomeX;
         MOUSE_Y       <= HomeY;
         MOUSE_BUTTONS <= '0;
         DROP_CNT      <= '0;
      end else begin
         if (SEND_INTERRUPT && state_q == StIdle) begin
            status_q <= MOUSE_STATUS;
            dx_q     <= MOUSE_DX;
            dy_q     <= MOUSE_DY;
         end
         if (SEND_INTERRUPT && state_q != StIdle && DROP_CNT != 8'hFF) begin
            DROP_CNT <= DROP_CNT + 8'd1;
         end
         if (state_q == StSum) begin
            sum_x_q <= $signed({2'b00, MOUSE_X}) + dx_ext;
            sum_y_q <= $signed({2'b00, MOUSE_Y}) + dy_ext;
         end
         if (state_q == StClamp) begin
            MOUSE_X       <= clamp(sum_x_q, MaxX);
            MOUSE_Y       <= clamp(sum_y_q, MaxY);
            MOUSE_BUTTONS <= status_q[2:0];
         end
      end
   end

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Scoreboard bench: a packet-level model predicts each update; a monitor checks every POS_VALID.
module tb_mouse_position_tracker;

   localparam int LX = 160;
   localparam int LY = 120;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       SEND_INTERRUPT = 1'b0;
   logic [7:0] MOUSE_STATUS = '0;
   logic [7:0] MOUSE_DX = '0;
   logic [7:0] MOUSE_DY = '0;
   logic [7:0] MOUSE_X;
   logic [7:0] MOUSE_Y;
   logic [2:0] MOUSE_BUTTONS;
   logic       POS_VALID;
   logic       BUSY;
   logic [7:0] DROP_CNT;

   mouse_position_tracker #(
      .LIMIT_X(LX),
      .LIMIT_Y(LY)
   ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .SEND_INTERRUPT(SEND_INTERRUPT),
      .MOUSE_STATUS  (MOUSE_STATUS),
      .MOUSE_DX      (MOUSE_DX),
      .MOUSE_DY      (MOUSE_DY),
      .MOUSE_X       (MOUSE_X),
      .MOUSE_Y       (MOUSE_Y),
      .MOUSE_BUTTONS (MOUSE_BUTTONS),
      .POS_VALID     (POS_VALID),
      .BUSY          (BUSY),
      .DROP_CNT      (DROP_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int x;
      int y;
      int btn;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   mx, my, busy_left, drops;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   // Signed delta from the 9-bit two's complement value {sign, byte}; overflow means no motion.
   function automatic int delta(input bit ovf, input bit sgn, input logic [7:0] b);
      if (ovf) return 0;
      return sgn ? int'(b) - 256 : int'(b);
   endfunction

   task automatic apply_reset();
      RESET = 1'b1;
      #2;
      check("rst_x", MOUSE_X, LX / 2);
      check("rst_y", MOUSE_Y, LY / 2);
      check("rst_btn", MOUSE_BUTTONS, 0);
      check("rst_valid", POS_VALID, 0);
      check("rst_busy", BUSY, 0);
      check("rst_drop", DROP_CNT, 0);
      RESET = 1'b0;
      exp_q.delete();
      mx = LX / 2;
      my = LY / 2;
      busy_left = 0;
      drops = 0;
   endtask

   // One clock: drive a (possibly absent) packet, then update the model and check per-cycle status.
   task automatic cycle(input bit pulse, input logic [7:0] st, input logic [7:0] dx,
                        input logic [7:0] dy);
      bit   accept;
      bit   drop;
      int   dyv;
      exp_t e;
      SEND_INTERRUPT = pulse;
      MOUSE_STATUS   = st;
      MOUSE_DX       = dx;
      MOUSE_DY       = dy;
      accept = pulse && (busy_left == 0);
      drop   = pulse && (busy_left != 0);
      @(posedge CLK);
      #1;
      SEND_INTERRUPT = 1'b0;
      if (accept) begin
         dyv = delta(st[7], st[5], dy);
`ifdef MOUSE_POS_INVERT_Y_EN
         dyv = -dyv;
`endif
         mx = clampi(mx + delta(st[6], st[4], dx), LX - 1);
         my = clampi(my + dyv, LY - 1);
         e.x = mx;
         e.y = my;
         e.btn = int'(st[2:0]);
         exp_q.push_back(e);
         busy_left = 3;
      end else if (busy_left > 0) begin
         busy_left--;
      end
      if (drop && drops < 255) drops++;
      check("drop_cnt", DROP_CNT, drops);
      check("busy", BUSY, int'(busy_left != 0));
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (!RESET && POS_VALID) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pos_valid: got 1, expected 0 (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            check("sb_x", MOUSE_X, e.x);
            check("sb_y", MOUSE_Y, e.y);
            check("sb_btn", MOUSE_BUTTONS, e.btn);
         end
      end
   end

   initial begin
      int bcnt;
      #1;
      apply_reset();
      @(posedge CLK);
      #1;

      // Basic move with latency check
      cycle(1'b1, 8'h08, 8'h05, 8'h03);
      check("lat_valid_e1", POS_VALID, 0);
      idle(1);
      check("lat_valid_e2", POS_VALID, 0);
      idle(1);
      check("lat_valid_e3", POS_VALID, 1);
      check("basic_x", MOUSE_X, 85);
`ifdef MOUSE_POS_INVERT_Y_EN
      check("basic_y", MOUSE_Y, 57);
`else
      check("basic_y", MOUSE_Y, 63);
`endif
      idle(1);
      check("valid_one_cycle", POS_VALID, 0);

      // Low and high clamps
      apply_reset();
      cycle(1'b1, 8'h18, 8'h00, 8'h00);
      idle(2);
      check("clamp_low_x", MOUSE_X, 0);
      idle(1);
      cycle(1'b1, 8'h08, 8'hFF, 8'h00);
      idle(3);
      cycle(1'b1, 8'h08, 8'hFF, 8'h00);
      idle(2);
      check("clamp_high_x", MOUSE_X, LX - 1);
      idle(1);

      // Both overflow bits: position held, buttons still update
      cycle(1'b1, 8'hC9, 8'h7F, 8'h7F);
      idle(2);
      check("ovf_valid", POS_VALID, 1);
      check("ovf_x", MOUSE_X, LX - 1);
      check("ovf_y", MOUSE_Y, LY / 2);
      check("ovf_btn", MOUSE_BUTTONS, 1);
      idle(1);

      // Back-to-back interrupts and drop saturation
      apply_reset();
      bcnt = 0;
      repeat (4) begin
         cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
         if (BUSY) bcnt++;
      end
      idle(2);
      check("b2b_busy_cycles", bcnt, 3);
      check("b2b_drop3", DROP_CNT, 3);
      repeat (420) cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
      idle(4);
      check("drop_saturate", DROP_CNT, 255);

      // Reset while in SUM abandons the packet
      apply_reset();
      cycle(1'b1, 8'h08, 8'h05, 8'h03);
      apply_reset();
      idle(4);
      check("rst_mid_x", MOUSE_X, LX / 2);
      check("rst_mid_y", MOUSE_Y, LY / 2);
      cycle(1'b1, 8'h08, 8'h05, 8'h03);
      idle(2);
      check("post_rst_x", MOUSE_X, 85);
      idle(1);

      // Random traffic
      apply_reset();
      repeat (600) begin
         cycle($urandom_range(0, 9) < 4, 8'($urandom), 8'($urandom), 8'($urandom));
      end
      idle(6);
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
